// File: rtl/blur_pixel_writer.sv
`default_nettype none
// ============================================================================
// Module      : blur_pixel_writer
// Description : Write-back stage for blurred pixels: input FIFO, col/row and
//               linear address generation, write strobes, frame-done pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module blur_pixel_writer #(
  parameter int IMG_WIDTH  = 31,
  parameter int IMG_HEIGHT = 31,
  parameter int PIX_W      = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W     = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [PIX_W-1:0]  in_data,
  output logic              in_ready,
  input  logic              wr_stall,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [PIX_W-1:0]  wr_data,
  output logic [7:0]        col,
  output logic [7:0]        row,
  output logic              busy,
  output logic              done
);

  localparam int c_PTR_W = $clog2(FIFO_DEPTH);
  localparam int c_TOTAL = IMG_WIDTH * IMG_HEIGHT;
  localparam int c_CNT_W = $clog2(c_TOTAL + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t r_state, w_state_next;
  logic   w_start_frame;

  logic [PIX_W-1:0]   r_mem [FIFO_DEPTH];
  logic [c_PTR_W:0]   r_wptr, r_rptr;
  logic [c_CNT_W-1:0] r_acc;
  logic [ADDR_W-1:0]  r_addr;
  logic [7:0]         r_col, r_row;
  logic               r_wr_en, r_done;
  logic [ADDR_W-1:0]  r_wr_addr;
  logic [PIX_W-1:0]   r_wr_data;

  logic w_empty, w_full, w_push, w_pop, w_last, w_in_ready;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (r_wptr[c_PTR_W] != r_rptr[c_PTR_W]) &&
                   (r_wptr[c_PTR_W-1:0] == r_rptr[c_PTR_W-1:0]);

  assign w_in_ready = (r_state == S_RUN) && !w_full && (r_acc < c_CNT_W'(c_TOTAL));
  assign w_push     = in_valid && w_in_ready;
  assign w_pop      = (r_state == S_RUN) && !w_empty && !wr_stall;
  assign w_last     = (r_col == 8'(IMG_WIDTH - 1)) && (r_row == 8'(IMG_HEIGHT - 1));

  always_comb begin
    w_state_next  = r_state;
    w_start_frame = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_next  = S_RUN;
          w_start_frame = 1'b1;
        end
      end
      S_RUN: begin
        if (w_pop && w_last) w_state_next = S_DONE;
      end
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_acc     <= '0;
      r_addr    <= '0;
      r_col     <= '0;
      r_row     <= '0;
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
      r_done    <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_wr_en <= w_pop;
      r_done  <= (r_state == S_DONE);
      if (w_start_frame) begin
        r_wptr <= '0;
        r_rptr <= '0;
        r_acc  <= '0;
        r_addr <= '0;
        r_col  <= '0;
        r_row  <= '0;
      end else begin
        if (w_push) begin
          r_wptr <= r_wptr + (c_PTR_W + 1)'(1);
          r_acc  <= r_acc + c_CNT_W'(1);
        end
        if (w_pop) begin
          r_rptr    <= r_rptr + (c_PTR_W + 1)'(1);
          r_wr_data <= r_mem[r_rptr[c_PTR_W-1:0]];
          r_wr_addr <= r_addr;
          // Counters stay on the final pixel once the frame is complete.
          if (!w_last) begin
            r_addr <= r_addr + ADDR_W'(1);
            if (r_col == 8'(IMG_WIDTH - 1)) begin
              r_col <= '0;
              r_row <= r_row + 8'd1;
            end else begin
              r_col <= r_col + 8'd1;
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr[c_PTR_W-1:0]] <= in_data;
  end

  assign in_ready = w_in_ready;
  assign wr_en    = r_wr_en;
  assign wr_addr  = r_wr_addr;
  assign wr_data  = r_wr_data;
  assign col      = r_col;
  assign row      = r_row;
  assign busy     = (r_state != S_IDLE);
  assign done     = r_done;

endmodule
`default_nettype wire

// File: tb/tb_blur_pixel_writer.sv
`default_nettype none
// ============================================================================
// Module      : tb_blur_pixel_writer
// Description : Randomized scoreboard bench for blur_pixel_writer (4x2 frame).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_blur_pixel_writer;

  localparam int W     = 4;
  localparam int H     = 2;
  localparam int TOTAL = W * H;
  localparam int DEPTH = 4;

  logic       clk;
  logic       rst;
  logic       start;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       wr_stall;
  logic       wr_en;
  logic [9:0] wr_addr;
  logic [7:0] wr_data;
  logic [7:0] col;
  logic [7:0] row;
  logic       busy;
  logic       done;

  blur_pixel_writer #(
    .IMG_WIDTH (W),
    .IMG_HEIGHT(H),
    .PIX_W     (8),
    .FIFO_DEPTH(DEPTH),
    .ADDR_W    (10)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .in_valid(in_valid),
    .in_data (in_data),
    .in_ready(in_ready),
    .wr_stall(wr_stall),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .col     (col),
    .row     (row),
    .busy    (busy),
    .done    (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int done_count = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp_v);
    end
  endfunction

  typedef struct {
    int         addr;
    logic [7:0] data;
  } exp_t;

  exp_t exp_q[$];

  // Frame-level reference: 0 idle, 1 running, 2 finishing.
  int m_state = 0;
  int acc = 0;
  int wrn = 0;
  bit m_exp_wr = 0;
  bit m_exp_done = 0;
  bit m_rst_edge = 0;
  bit m_just_started = 0;

  always @(posedge clk) begin
    int occ;
    bit do_pop;
    occ            = acc - wrn;
    do_pop         = 1'b0;
    m_exp_wr       = 1'b0;
    m_exp_done     = 1'b0;
    m_just_started = 1'b0;
    if (!rst) begin
      m_state    = 0;
      acc        = 0;
      wrn        = 0;
      m_rst_edge = 1'b1;
      exp_q.delete();
    end else begin
      m_rst_edge = 1'b0;
      case (m_state)
        0: begin
          if (start) begin
            m_state        = 1;
            acc            = 0;
            wrn            = 0;
            m_just_started = 1'b1;
          end
        end
        1: begin
          do_pop = (occ > 0) && !wr_stall;
          if (in_valid && in_ready) begin
            exp_q.push_back(exp_t'{addr: acc, data: in_data});
            acc++;
          end
          if (do_pop) begin
            m_exp_wr = 1'b1;
            wrn++;
            if (wrn == TOTAL) m_state = 2;
          end
        end
        default: begin
          m_state    = 0;
          m_exp_done = 1'b1;
        end
      endcase
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (m_rst_edge) begin
      chk("rst_wr_en", 32'(wr_en), 32'(0));
      chk("rst_in_ready", 32'(in_ready), 32'(0));
      chk("rst_busy", 32'(busy), 32'(0));
      chk("rst_done", 32'(done), 32'(0));
      chk("rst_col", 32'(col), 32'(0));
      chk("rst_row", 32'(row), 32'(0));
      chk("rst_wr_addr", 32'(wr_addr), 32'(0));
      chk("rst_wr_data", 32'(wr_data), 32'(0));
    end else begin
      chk("wr_en_timing", 32'(wr_en), 32'(m_exp_wr));
      chk("in_ready", 32'(in_ready),
          32'((m_state == 1) && ((acc - wrn) < DEPTH) && (acc < TOTAL)));
      chk("busy", 32'(busy), 32'(m_state != 0));
      chk("done", 32'(done), 32'(m_exp_done));
      if (done) done_count++;
      if (m_just_started) begin
        chk("start_col", 32'(col), 32'(0));
        chk("start_row", 32'(row), 32'(0));
      end
      if (wr_en) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_write", 32'(1), 32'(0));
        end else begin
          e = exp_q.pop_front();
          chk("wr_addr", 32'(wr_addr), 32'(e.addr));
          chk("wr_data", 32'(wr_data), 32'(e.data));
          if (e.addr != TOTAL - 1) begin
            chk("next_col", 32'(col), 32'((e.addr + 1) % W));
            chk("next_row", 32'(row), 32'((e.addr + 1) / W));
          end
        end
      end
    end
  end

  // mode 0: plain frame, 1: start pulsed during the addr-3 write, 2: reset after 5 writes
  task automatic run_frame(input int vpct, input int spct, input int stall_cyc,
                           input bit seq_data, input int mode);
    int cyc;
    cyc = 0;
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    while (m_state != 0 && cyc < 400) begin
      if (stall_cyc > 0 && cyc == stall_cyc) chk("bp_accepted", 32'(acc), 32'(DEPTH));
      if (mode == 2 && wrn >= 5) begin
        rst      = 1'b0;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        break;
      end
      in_valid = ($urandom_range(99) < vpct);
      in_data  = seq_data ? 8'(8'h10 + acc) : 8'($urandom);
      wr_stall = (cyc < stall_cyc) ? 1'b1 : ($urandom_range(99) < spct);
      start    = (mode == 1 && wrn == 3);
      @(posedge clk); #1;
      cyc++;
    end
    if (cyc >= 400) chk("frame_timeout", 32'(cyc), 32'(0));
    in_valid = 1'b0;
    wr_stall = 1'b0;
    start    = 1'b0;
  endtask

  initial begin
    int frames;
    rst      = 1'b0;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    wr_stall = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      start    = 1'($urandom);
      in_valid = 1'($urandom);
      in_data  = 8'($urandom);
      wr_stall = 1'($urandom);
    end
    @(posedge clk); #1;
    rst      = 1'b1;
    start    = 1'b0;
    in_valid = 1'b0;
    wr_stall = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    frames = 0;
    run_frame(100, 0, 0, 1'b1, 0);   frames++;  // back-to-back frame, overrun valid
    run_frame(100, 0, 10, 1'b1, 0);  frames++;  // backpressure
    run_frame(100, 0, 0, 1'b1, 1);   frames++;  // start while busy
    run_frame(100, 0, 0, 1'b1, 2);              // aborted by reset
    run_frame(100, 0, 0, 1'b1, 0);   frames++;
    repeat (6) begin
      run_frame($urandom_range(30, 100), $urandom_range(0, 60), 0, 1'b0, 0);
      frames++;
    end

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_empty", 32'(exp_q.size()), 32'(0));
    chk("done_pulses", 32'(done_count), 32'(frames));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/blur_pixel_writer.md
Name: blur_pixel_writer

Overview:
Write-back stage downstream of the Gaussian blur datapath. It accepts blurred pixels over a valid/ready stream and buffers them in a small FIFO. It generates the column/row position and linear address for each pixel; the column wraps at IMG_WIDTH-1, in the same style as the existing wrap-around column counter. It issues one-cycle write strobes to the output image memory and signals frame completion.

Parameters:
IMG_WIDTH, 31, pixels per row; column counts 0..IMG_WIDTH-1.
IMG_HEIGHT, 31, rows per frame.
PIX_W, 8, pixel data width.
FIFO_DEPTH, 4, input buffer entries; power of 2, minimum 2.
ADDR_W, 10, write address width; must satisfy 2^ADDR_W >= IMG_WIDTH*IMG_HEIGHT.

Ports:
clk  in  1  system clock, all logic on rising edge.
rst  in  1  synchronous, active-low reset; sampled on clk rising edge; 0 = reset.
start  in  1  begin a frame; honoured only in IDLE.
in_valid  in  1  blurred pixel present on in_data.
in_data  in  PIX_W  blurred pixel value.
in_ready  out  1  stage can accept a pixel this cycle.
wr_stall  in  1  output memory cannot take a write this cycle.
wr_en  out  1  one-cycle write strobe.
wr_addr  out  ADDR_W  linear address = row*IMG_WIDTH + col.
wr_data  out  PIX_W  pixel being written.
col  out  8  column of the next pixel to be written.
row  out  8  row of the next pixel to be written.
busy  out  1  high in RUN.
done  out  1  one-cycle pulse after the last pixel of the frame is written.

Behaviour:
- Reset (rst=0 at an edge): state=IDLE; FIFO emptied; accepted-count=0. All outputs go to 0: wr_en, wr_addr, wr_data, col, row, busy, done, in_ready. Reset mid-frame aborts the frame; no further writes are issued.
- FSM states: IDLE, RUN, DONE.
  - IDLE: start=1 clears col, row, the address counter and accepted-count, then moves to RUN.
  - RUN: moves to DONE on the edge that issues the write for col=IMG_WIDTH-1, row=IMG_HEIGHT-1.
  - DONE: done=1 for exactly one cycle, then IDLE.
  - start in RUN or DONE is ignored.
- Input side:
  - in_ready = (state==RUN) && FIFO not full && accepted-count < IMG_WIDTH*IMG_HEIGHT. It is combinational from registered state.
  - A push happens when in_valid && in_ready at an edge.
  - Pixels beyond the frame total are never accepted; in_ready stays 0.
- Pop/write side:
  - At an edge in RUN with FIFO not empty and wr_stall=0: pop the head, register it to wr_data, set wr_en=1, set wr_addr = address counter, then advance the counters.
  - Otherwise wr_en=0; wr_data and wr_addr hold their values.
- Counters:
  - Address counter increments by 1 per write.
  - col increments per write; col==IMG_WIDTH-1 wraps col to 0 and increments row.
  - row never exceeds IMG_HEIGHT-1; counters freeze after the final write.
- Simultaneous push and pop in one cycle is legal; occupancy is unchanged. Push is blocked when full even if a pop occurs in the same cycle.
- Latency: a pixel pushed at edge k into an empty FIFO appears with wr_en=1 after edge k+1, i.e. 2 cycles from in_valid to wr_en. With sustained in_valid and wr_stall=0, throughput is 1 pixel/cycle.
- done rises the cycle after the final wr_en pulse; busy falls in the same cycle.
- Write order is strictly arrival order; no pixel is dropped or duplicated.

Test Plan:
1. Reset: hold rst=0 for 3 cycles with random inputs -> wr_en, in_ready, busy, done, col, row, wr_addr all 0.
2. Full frame, IMG_WIDTH=4, IMG_HEIGHT=2: start, stream in_data 0x10..0x17 back-to-back -> wr_addr 0..7 with matching data. col sequence 0,1,2,3,0,1,2,3; row steps 0 to 1 after addr 3. done pulses exactly once, one cycle after the addr-7 write.
3. Backpressure: hold wr_stall=1 while streaming -> exactly FIFO_DEPTH (4) pixels accepted, then in_ready=0. Release wr_stall -> 4 consecutive writes with data in arrival order.
4. Overrun: keep in_valid=1 after the 8th accepted pixel in scenario 2 -> in_ready stays 0, no 9th write, and no extra push into the FIFO.
5. Start while busy: pulse start at the write for addr 3 -> counters are not reset, and the frame completes normally with addr 4..7.
6. Reset mid-frame: drive rst=0 after 5 writes, then start a new frame -> no writes during reset, and the new frame starts at wr_addr 0, col 0, row 0.
